// File: rtl/sink_buffered.sv
`default_nettype none

`ifndef SIZE
`define SIZE 8
`endif

// ============================================================================
//  Module   : sink_buffered
//  Purpose  : NoC traffic sink. It accepts flits over a two-phase req/ack
//             handshake, buffers them and drains them at a programmable rate.
//  Revision : 1.0
// ============================================================================
module sink_buffered #(
  parameter int ID           = 0,
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 2,
  parameter int DRAIN_PERIOD = 3,
  parameter int CHECK_DEST   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [`SIZE-1:0]  data,
  output logic              ack,
  output logic              out_valid,
  output logic [`SIZE-1:0]  out_data,
  output logic [ADDR_W:0]   level,
  output logic [7:0]        rx_count,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W:0]   C_DEPTH   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   C_LVL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [`SIZE-1:0]  C_ID      = ID[`SIZE-1:0];

  logic [`SIZE-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_req_seen;

  logic              w_tick;
  logic              w_accept;
  logic              w_drain;
  logic              w_mismatch;
  logic [`SIZE-1:0]  w_head;

  // Fullness is judged on the current level, so a same-cycle drain never frees a slot early.
  assign w_accept   = (req ^ r_req_seen) && (level < C_DEPTH);
  assign w_drain    = w_tick && (level != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_mismatch = (CHECK_DEST != 0) && (w_head != C_ID);

  generate
    if (DRAIN_PERIOD > 1) begin : g_div
      localparam int DIV_W = $clog2(DRAIN_PERIOD);
      localparam logic [DIV_W-1:0] C_LAST    = DIV_W'(DRAIN_PERIOD - 1);
      localparam logic [DIV_W-1:0] C_DIV_ONE = DIV_W'(1);
      logic [DIV_W-1:0] r_div;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          r_div <= '0;
        else if (r_div == C_LAST)
          r_div <= '0;
        else
          r_div <= r_div + C_DIV_ONE;
      end

      assign w_tick = (r_div == C_LAST);
    end else begin : g_nodiv
      assign w_tick = 1'b1;
    end
  endgenerate

  // Storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem[r_wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_req_seen <= 1'b0;
      ack        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      level      <= '0;
      rx_count   <= '0;
      err_count  <= '0;
    end else begin
      out_valid <= w_drain;
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + C_PTR_ONE;
        r_req_seen <= req;
        ack        <= ~ack;
        if (rx_count != 8'hFF)
          rx_count <= rx_count + 8'd1;
      end
      if (w_drain) begin
        out_data <= w_head;
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        if (w_mismatch && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
      case ({w_accept, w_drain})
        2'b10:   level <= level + C_LVL_ONE;
        2'b01:   level <= level - C_LVL_ONE;
        default: level <= level;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_drain)
      $display("%0t sink %0d consumed %0h", $time, ID, w_head);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sink_buffered.sv
`default_nettype none

`ifndef SIZE
`define SIZE 8
`endif

// ============================================================================
//  Module   : tb_sink_buffered
//  Purpose  : Directed, table-driven bench for sink_buffered across three
//             parameter sets (slow drain, very slow drain, drain every cycle).
//  Revision : 1.0
// ============================================================================
module tb_sink_buffered;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             req_v  [3];
  logic [`SIZE-1:0] data_v [3];
  logic             ack_v  [3];
  logic             ov_v   [3];
  logic [`SIZE-1:0] od_v   [3];
  logic [2:0]       lvl_v  [3];
  logic [7:0]       rx_v   [3];
  logic [7:0]       err_v  [3];

  int nchk = 0;
  int nerr = 0;

  logic [`SIZE-1:0] got0[$];
  logic [`SIZE-1:0] got1[$];
  logic [`SIZE-1:0] got2[$];
  logic [2:0]       maxlvl2 = 3'd0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] err;
    logic [7:0] rx;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] bp  [6];
  logic [7:0] st  [20];

  sink_buffered #(.ID(4), .DEPTH(4), .ADDR_W(2), .DRAIN_PERIOD(3), .CHECK_DEST(1)) u0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .data(data_v[0]), .ack(ack_v[0]),
    .out_valid(ov_v[0]), .out_data(od_v[0]), .level(lvl_v[0]),
    .rx_count(rx_v[0]), .err_count(err_v[0]));

  sink_buffered #(.ID(2), .DEPTH(4), .ADDR_W(2), .DRAIN_PERIOD(8), .CHECK_DEST(1)) u1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .data(data_v[1]), .ack(ack_v[1]),
    .out_valid(ov_v[1]), .out_data(od_v[1]), .level(lvl_v[1]),
    .rx_count(rx_v[1]), .err_count(err_v[1]));

  sink_buffered #(.ID(2), .DEPTH(4), .ADDR_W(2), .DRAIN_PERIOD(1), .CHECK_DEST(0)) u2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .data(data_v[2]), .ack(ack_v[2]),
    .out_valid(ov_v[2]), .out_data(od_v[2]), .level(lvl_v[2]),
    .rx_count(rx_v[2]), .err_count(err_v[2]));

  always @(negedge clk) begin
    if (ov_v[0] === 1'b1) got0.push_back(od_v[0]);
    if (ov_v[1] === 1'b1) got1.push_back(od_v[1]);
    if (ov_v[2] === 1'b1) got2.push_back(od_v[2]);
    if (lvl_v[2] > maxlvl2) maxlvl2 = lvl_v[2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two-phase source: toggle req, then wait (bounded) for the matching ack.
  task automatic send(input int k, input logic [7:0] d);
    int n = 0;
    data_v[k] = d;
    req_v[k]  = ~req_v[k];
    while (ack_v[k] !== req_v[k] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout[%0d]: ack %0b never matched req %0b", k, ack_v[k], req_v[k]);
    end
  endtask

  task automatic wait_pulse(input int k, input int lim);
    int n = 0;
    while (ov_v[k] !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      nchk++;
      nerr++;
      $display("FAIL pulse_timeout[%0d]: out_valid got 0 for %0d cycles, expected 1", k, lim);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    logic exp_a;
    int   n;

    tbl[0] = '{d: 8'h04, err: 8'd0, rx: 8'd2};
    tbl[1] = '{d: 8'h09, err: 8'd1, rx: 8'd3};
    tbl[2] = '{d: 8'h04, err: 8'd1, rx: 8'd4};
    tbl[3] = '{d: 8'h00, err: 8'd2, rx: 8'd5};
    tbl[4] = '{d: 8'hFF, err: 8'd3, rx: 8'd6};
    tbl[5] = '{d: 8'h04, err: 8'd3, rx: 8'd7};
    bp[0] = 8'h02; bp[1] = 8'h04; bp[2] = 8'h02;
    bp[3] = 8'h07; bp[4] = 8'h02; bp[5] = 8'h02;
    for (int i = 0; i < 20; i++) st[i] = 8'((i * 37) + 7);

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_v[k]  = 1'b0;
      data_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) step();
    chk("idle_ack", ack_v[0], 1'b0);
    chk("idle_level", lvl_v[0], 3'd0);
    chk("idle_rx", rx_v[0], 8'd0);
    chk("idle_err", err_v[0], 8'd0);
    chk("idle_no_valid", got0.size() + got1.size() + got2.size(), 0);

    // Single flit, ID=4
    data_v[0] = 8'h04;
    req_v[0]  = 1'b1;
    chk("single_ack_before_edge", ack_v[0], 1'b0);
    step();
    chk("single_ack", ack_v[0], 1'b1);
    chk("single_level", lvl_v[0], 3'd1);
    wait_pulse(0, 10);
    chk("single_data", od_v[0], 8'h04);
    chk("single_rx", rx_v[0], 8'd1);
    chk("single_err", err_v[0], 8'd0);
    chk("single_level_drained", lvl_v[0], 3'd0);
    step();
    chk("single_valid_pulse", ov_v[0], 1'b0);
    chk("single_data_held", od_v[0], 8'h04);
    chk("single_pulse_count", got0.size(), 1);

    // Table-driven flits through u0
    for (int i = 0; i < 6; i++) begin
      send(0, tbl[i].d);
      wait_pulse(0, 10);
      chk($sformatf("tbl%0d_data", i), od_v[0], tbl[i].d);
      chk($sformatf("tbl%0d_err", i), err_v[0], tbl[i].err);
      chk($sformatf("tbl%0d_rx", i), rx_v[0], tbl[i].rx);
      step();
    end

    // Backpressure on u1 (drain every 8 cycles); align to a drain first
    send(1, bp[0]);
    wait_pulse(1, 20);
    for (int i = 1; i < 5; i++) send(1, bp[i]);
    chk("bp_full", lvl_v[1], 3'd4);
    data_v[1] = bp[5];
    req_v[1]  = ~req_v[1];
    exp_a     = ~req_v[1];
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_pending_ack", ack_v[1], exp_a);
      chk("bp_pending_level", lvl_v[1], 3'd4);
    end
    step();
    chk("bp_drain_valid", ov_v[1], 1'b1);
    chk("bp_drain_level", lvl_v[1], 3'd3);
    chk("bp_drain_no_accept", ack_v[1], exp_a);
    step();
    chk("bp_late_accept", ack_v[1], req_v[1]);
    chk("bp_late_level", lvl_v[1], 3'd4);
    n = 0;
    while (got1.size() < 6 && n < 100) begin
      step();
      n++;
    end
    chk("bp_count", got1.size(), 6);
    chk("bp_rx", rx_v[1], 8'd6);
    chk("bp_err", err_v[1], 8'd2);
    for (int i = 0; i < 6; i++)
      if (i < got1.size()) chk($sformatf("bp_order%0d", i), got1[i], bp[i]);

    // Drain every cycle on u2: no bypass, then a 20-flit stream
    data_v[2] = st[0];
    req_v[2]  = 1'b1;
    step();
    chk("nobyp_ack", ack_v[2], 1'b1);
    chk("nobyp_level", lvl_v[2], 3'd1);
    chk("nobyp_valid", ov_v[2], 1'b0);
    step();
    chk("nobyp_drain_valid", ov_v[2], 1'b1);
    chk("nobyp_drain_data", od_v[2], st[0]);
    chk("nobyp_drain_level", lvl_v[2], 3'd0);
    for (int i = 1; i < 20; i++) send(2, st[i]);
    n = 0;
    while (got2.size() < 20 && n < 50) begin
      step();
      n++;
    end
    chk("wrap_count", got2.size(), 20);
    chk("wrap_rx", rx_v[2], 8'd20);
    chk("wrap_err_disabled", err_v[2], 8'd0);
    chk("wrap_maxlevel", maxlvl2, 3'd1);
    for (int i = 0; i < 20; i++)
      if (i < got2.size()) chk($sformatf("wrap_order%0d", i), got2[i], st[i]);

    // Reset mid-operation on u1 with level 3 and a toggle pending
    n = 0;
    while (lvl_v[1] != 3'd3 && n < 10) begin
      send(1, 8'h02);
      n++;
    end
    chk("rst_pre_level", lvl_v[1], 3'd3);
    data_v[1] = 8'h77;
    req_v[1]  = ~req_v[1];
    #2 reset = 1'b1;
    #1;
    chk("rst_ack", ack_v[1], 1'b0);
    chk("rst_level", lvl_v[1], 3'd0);
    chk("rst_rx", rx_v[1], 8'd0);
    chk("rst_err", err_v[1], 8'd0);
    chk("rst_valid", ov_v[1], 1'b0);
    chk("rst_data", od_v[1], 8'h00);
    for (int k = 0; k < 3; k++) req_v[k] = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_level", lvl_v[1], 3'd0);
    chk("post_rst_ack", ack_v[1], 1'b0);
    send(1, 8'h02);
    chk("post_rst_ack_toggle", ack_v[1], 1'b1);
    chk("post_rst_rx", rx_v[1], 8'd1);
    wait_pulse(1, 20);
    chk("post_rst_data", od_v[1], 8'h02);
    chk("post_rst_err", err_v[1], 8'd0);
    chk("post_rst_rx_final", rx_v[1], 8'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sink_buffered.md
Name: sink_buffered

Overview:
- Traffic sink for the NoC test environment. It sits directly downstream of a flit source or router output port.
- Receives flits over a two-phase (transition-signalled) req/ack handshake and buffers them in a small FIFO.
- Drains the FIFO at a programmable rate to model a slow consumer, which exercises upstream backpressure.
- Checks each consumed flit against the expected destination id and keeps saturating receive and error counters.

Parameters:
- ID, 0, this sink's node id; consumed flits are compared against it.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 2, log2(DEPTH).
- DRAIN_PERIOD, 3, cycles between drain opportunities; 1 means drain every cycle.
- CHECK_DEST, 1, 1 enables the destination check; 0 means err_count stays 0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req  input  1  two-phase request; each toggle signals a new flit.
- data  input  `SIZE  flit payload; upstream holds it stable until ack toggles.
- ack  output  1  two-phase acknowledge; toggles once per accepted flit.
- out_valid  output  1  one-cycle pulse when a flit is consumed from the FIFO.
- out_data  output  `SIZE  consumed flit; valid while out_valid=1 and held otherwise.
- level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- rx_count  output  8  flits accepted into the FIFO, saturates at 255.
- err_count  output  8  consumed flits with out_data != ID, saturates at 255.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - outputs: ack, out_valid, out_data, level, rx_count, err_count;
  - internal state: req_seen, FIFO pointers, drain divider.
- Reset mid-operation discards buffered flits and any pending request.
- Request detection: pending = req ^ req_seen. The register req_seen updates only on acceptance, so a toggle arriving while the FIFO is full stays pending and is never lost.
- Accept condition: pending && level < DEPTH, evaluated before this cycle's drain. A full FIFO does not accept, even if a drain happens in the same cycle.
- On accept (registered, at the clock edge):
  - write data to FIFO[wr_ptr] and increment wr_ptr (wraps mod DEPTH);
  - req_seen <= req;
  - ack <= ~ack;
  - rx_count increments unless it is already 255.
- Handshake latency: req toggles at edge k, so the sink accepts and toggles ack at edge k+1 when not full. At most one flit is accepted per cycle. A second req toggle is impossible before ack toggles, because upstream obeys the two-phase protocol.
- Drain divider: free-running 0..DRAIN_PERIOD-1; tick = (div == DRAIN_PERIOD-1). For DRAIN_PERIOD=1, tick is constant 1.
- Drain on tick && level > 0:
  - out_data <= FIFO[rd_ptr] and out_valid <= 1;
  - increment rd_ptr (wraps);
  - if CHECK_DEST and FIFO[rd_ptr] != ID, increment err_count (saturating).
- A tick with level == 0 is lost: the divider keeps counting and out_valid stays 0.
- out_valid is 0 in every cycle without a drain. out_data holds its last value.
- level_next = level + accept - drain.
  - Simultaneous accept and drain leaves level unchanged.
  - Accept and drain may both occur when level is between 1 and DEPTH-1.
  - Drain with level==DEPTH and no accept gives DEPTH-1; the pending flit is accepted the next cycle.
- With level==0, accept and drain cannot coincide: there is no bypass, and a flit is visible to drain only the cycle after it is written.
- Arithmetic: pointers are ADDR_W bits and wrap naturally; level is ADDR_W+1 bits and never exceeds DEPTH.
- Simulation-only: $display on each consume, reporting time, ID and out_data.

Test Plan:
- Reset then idle, req=0 -> ack=0, level=0, out_valid never 1, rx_count=0, err_count=0.
- Single flit: data=4 with ID=4, req 0->1 at edge 2 -> ack=1 after edge 3 and level=1. One out_valid pulse with out_data=4 at the next tick; rx_count=1, err_count=0.
- Backpressure: DEPTH=4, DRAIN_PERIOD=8, a source sending 6 flits back-to-back ->
  - level reaches 4 and ack stops toggling with flit 5 pending;
  - after the first drain, flit 5 is accepted the following cycle;
  - final rx_count=6, six out_valid pulses in send order, no loss or duplication.
- Destination mismatch: ID=2, flits with data 2,4,2,7 -> err_count=2. With CHECK_DEST=0, err_count=0.
- Wrap and simultaneous events: DRAIN_PERIOD=1, 20 flits streamed -> pointers wrap multiple times, level stays ≤1, data order is preserved, rx_count=20.
- Reset mid-operation: assert reset with level=3 and a req toggle pending -> everything cleared immediately (async). After release with req also reset to 0, the next flit is handled normally and rx_count=1.
